// File: rtl/dcache_pkg.sv
// Shared definitions for the store-buffer-side data cache.
// Holds the controller state encoding, the address-field widths for the
// default geometry, the line width and a helper that derives the index width.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    FILL  = 2'd2
  } state_t;

  localparam int LINES_DEF = 4;
  localparam int LINE_W    = 128;
  localparam int OFFSET_W  = 2;   // word offset inside a 4-word line
  localparam int BYTE_W    = 2;   // byte bits below the word offset

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  localparam int INDEX_W = index_w(LINES_DEF);
  localparam int TAG_W   = 32 - OFFSET_W - BYTE_W - INDEX_W;

endpackage

// File: rtl/dcache_sb_port_if.sv
// Bundle of the store-buffer drain port, the load port and the line-wide
// memory bus of the data cache.
//   slave  : the cache side (accepts drains/loads, issues memory requests)
//   master : the environment side (store buffer, load logic and main memory)
interface dcache_sb_port_if;
  import dcache_pkg::*;

  logic              sb_valid;
  logic [31:0]       sb_addr;
  logic [31:0]       sb_data;
  logic              sb_ready;

  logic              ld_req;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_data;
  logic              ld_hit;

  logic              dc_busy;

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;

  modport slave (
    input  sb_valid, sb_addr, sb_data, ld_req, ld_addr, mem_ack, mem_rdata,
    output sb_ready, ld_data, ld_hit, dc_busy, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output sb_valid, sb_addr, sb_data, ld_req, ld_addr, mem_ack, mem_rdata,
    input  sb_ready, ld_data, ld_hit, dc_busy, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dc_line_array.sv
// Tag/valid/dirty/data storage of the direct-mapped cache.
// Ports: clk, reset (sync, active-high, clears valid and dirty only);
//   rd_idx -> rd_valid/rd_dirty/rd_tag/rd_data  combinational read port
//   ww_*   single-word write (drains), sets dirty
//   lw_*   whole-line write (fills), sets tag and valid, clears dirty
module dc_line_array
  import dcache_pkg::*;
#(
  parameter int LINES = 4,
  parameter int IW    = 2,
  parameter int TW    = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IW-1:0]     rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TW-1:0]     rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              ww_en,
  input  logic [IW-1:0]     ww_idx,
  input  logic [1:0]        ww_off,
  input  logic [31:0]       ww_data,
  input  logic              lw_en,
  input  logic [IW-1:0]     lw_idx,
  input  logic [TW-1:0]     lw_tag,
  input  logic [LINE_W-1:0] lw_data
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TW-1:0]     tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (lw_en) begin
      valid_q[lw_idx] <= 1'b1;
      dirty_q[lw_idx] <= 1'b0;
    end else if (ww_en) begin
      dirty_q[ww_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a valid line.
  always_ff @(posedge clk) begin
    if (lw_en) begin
      tag_q[lw_idx]  <= lw_tag;
      data_q[lw_idx] <= lw_data;
    end else if (ww_en) begin
      data_q[ww_idx][{ww_off, 5'b0} +: 32] <= ww_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_sb_port.sv
// Data-cache side of the store-buffer drain path: direct-mapped, write-back,
// write-allocate cache serving the load port and committed store drains.
// Ports: clk, reset (sync, active-high); bus = dcache_sb_port_if.slave
//   (sb_valid/sb_addr/sb_data/sb_ready drain, ld_req/ld_addr/ld_data/ld_hit
//   load, dc_busy, mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata).
//
// state | meaning
// IDLE  | serve loads (priority) and drains; detect misses
// EVICT | write dirty victim line back, held until mem_ack
// FILL  | read missing line from memory, install on mem_ack
module dcache_sb_port
  import dcache_pkg::*;
#(
  parameter int LINES = LINES_DEF
) (
  input logic             clk,
  input logic             reset,
  dcache_sb_port_if.slave bus
);

  localparam int IW = index_w(LINES);
  localparam int TW = 32 - OFFSET_W - BYTE_W - IW;

  state_t      state_q, state_d;
  logic [27:0] miss_q, miss_d;     // miss line address, addr[31:4]

  logic [31:0]       req_addr;
  logic [IW-1:0]     rd_idx;
  logic              rd_valid, rd_dirty, hit, ww_en, lw_en;
  logic [TW-1:0]     rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              unused_bits;

  assign unused_bits = ^{bus.sb_addr[1:0], bus.ld_addr[1:0]};

  // Loads win arbitration, so the read port follows the load when present.
  assign req_addr = bus.ld_req ? bus.ld_addr : bus.sb_addr;
  assign rd_idx   = (state_q == IDLE) ? req_addr[4 +: IW] : miss_q[IW-1:0];
  assign hit      = rd_valid && (rd_tag == req_addr[31 -: TW]);
  assign bus.ld_data = rd_data[{bus.ld_addr[3:2], 5'b0} +: 32];

  dc_line_array #(.LINES(LINES), .IW(IW), .TW(TW)) u_lines (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .ww_en    (ww_en),
    .ww_idx   (rd_idx),
    .ww_off   (bus.sb_addr[3:2]),
    .ww_data  (bus.sb_data),
    .lw_en    (lw_en),
    .lw_idx   (miss_q[IW-1:0]),
    .lw_tag   (miss_q[27:IW]),
    .lw_data  (bus.mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    miss_d        = miss_q;
    bus.sb_ready  = 1'b0;
    bus.ld_hit    = 1'b0;
    bus.dc_busy   = (state_q != IDLE);
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    ww_en         = 1'b0;
    lw_en         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ld_req || bus.sb_valid) begin
          if (hit) begin
            bus.ld_hit   = bus.ld_req;
            bus.sb_ready = !bus.ld_req;
            ww_en        = !bus.ld_req;
          end else begin
            miss_d  = req_addr[31:4];
            state_d = (rd_valid && rd_dirty) ? EVICT : FILL;
          end
        end
      end
      EVICT: begin
        // Array is not written here, so victim address/data stay stable.
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {rd_tag, miss_q[IW-1:0], 4'b0};
        bus.mem_wdata = rd_data;
        if (bus.mem_ack) state_d = FILL;
      end
      FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {miss_q, 4'b0};
        if (bus.mem_ack) begin
          lw_en   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_sb_port.sv
module tb_dcache_sb_port;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dcache_sb_port_if bus ();

  dcache_sb_port #(.LINES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.sb_valid  = 1'b0;
    bus.sb_addr   = '0;
    bus.sb_data   = '0;
    bus.ld_req    = 1'b0;
    bus.ld_addr   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_sb_ready", bus.sb_ready, 0);
    chk("rst_ld_hit",   bus.ld_hit,   0);
    chk("rst_dc_busy",  bus.dc_busy,  0);
    chk("rst_mem_req",  bus.mem_req,  0);
    chk("rst_mem_we",   bus.mem_we,   0);
    chk("rst_mem_addr", bus.mem_addr, 0);

    // 1. cold load miss, memory acks on the third FILL cycle
    bus.ld_req  = 1'b1;
    bus.ld_addr = 32'h100;
    #1;
    chk("t1_miss_no_hit", bus.ld_hit, 0);
    tick();
    chk("t1_fill_busy", bus.dc_busy, 1);
    chk("t1_fill_req",  bus.mem_req, 1);
    chk("t1_fill_we",   bus.mem_we,  0);
    chk("t1_fill_addr", bus.mem_addr, 32'h100);
    tick();
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 128'h00000033_00000022_00000011_00000000;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("t1_hit",     bus.ld_hit,  1);
    chk("t1_data",    bus.ld_data, 32'h0);
    chk("t1_busy",    bus.dc_busy, 0);
    bus.ld_addr = 32'h10C;
    #1;
    chk("t1_data_w3", bus.ld_data, 32'h33);
    bus.ld_req = 1'b0;

    // 2. store hit
    bus.sb_valid = 1'b1;
    bus.sb_addr  = 32'h104;
    bus.sb_data  = 32'hDEADBEEF;
    #1;
    chk("t2_sb_ready", bus.sb_ready, 1);
    chk("t2_no_req",   bus.mem_req,  0);
    tick();
    bus.sb_valid = 1'b0;
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 32'h104;
    #1;
    chk("t2_ld_hit",  bus.ld_hit,  1);
    chk("t2_ld_data", bus.ld_data, 32'hDEADBEEF);
    bus.ld_req = 1'b0;

    // 3. conflict miss with dirty victim
    bus.sb_valid = 1'b1;
    bus.sb_addr  = 32'h140;
    bus.sb_data  = 32'hCAFEF00D;
    #1;
    chk("t3_miss_not_ready", bus.sb_ready, 0);
    tick();
    chk("t3_ev_req",   bus.mem_req,  1);
    chk("t3_ev_we",    bus.mem_we,   1);
    chk("t3_ev_addr",  bus.mem_addr, 32'h100);
    chk("t3_ev_w1",    bus.mem_wdata[63:32], 32'hDEADBEEF);
    chk("t3_ev_line",  bus.mem_wdata, 128'h00000033_00000022_DEADBEEF_00000000);
    chk("t3_ev_ready", bus.sb_ready, 0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("t3_fill_req",  bus.mem_req,  1);
    chk("t3_fill_we",   bus.mem_we,   0);
    chk("t3_fill_addr", bus.mem_addr, 32'h140);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 128'h00000073_00000072_00000071_00000070;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("t3_sb_ready", bus.sb_ready, 1);
    tick();
    bus.sb_valid = 1'b0;
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 32'h140;
    #1;
    chk("t3_ld_w0", bus.ld_data, 32'hCAFEF00D);
    bus.ld_addr = 32'h144;
    #1;
    chk("t3_ld_w1", bus.ld_data, 32'h71);
    chk("t3_ld_hit", bus.ld_hit, 1);

    // 4. load/drain collision
    bus.ld_addr  = 32'h148;
    bus.sb_valid = 1'b1;
    bus.sb_addr  = 32'h14C;
    bus.sb_data  = 32'h12345678;
    #1;
    chk("t4_ld_hit",   bus.ld_hit,   1);
    chk("t4_ld_data",  bus.ld_data,  32'h72);
    chk("t4_sb_block", bus.sb_ready, 0);
    tick();
    bus.ld_req = 1'b0;
    #1;
    chk("t4_sb_ready", bus.sb_ready, 1);
    tick();
    bus.sb_valid = 1'b0;
    bus.ld_req   = 1'b1;
    bus.ld_addr  = 32'h14C;
    #1;
    chk("t4_stored", bus.ld_data, 32'h12345678);

    // 5. slow memory: fill held ten cycles
    bus.ld_addr = 32'h250;
    #1;
    chk("t5_miss", bus.ld_hit, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_req_%0d", i),  bus.mem_req,  1);
      chk($sformatf("t5_addr_%0d", i), bus.mem_addr, 32'h250);
      chk($sformatf("t5_we_%0d", i),   bus.mem_we,   0);
      chk($sformatf("t5_busy_%0d", i), bus.dc_busy,  1);
      chk($sformatf("t5_nohit_%0d", i), bus.ld_hit,  0);
      tick();
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 128'h000000A3_000000A2_000000A1_000000A0;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("t5_hit",  bus.ld_hit,  1);
    chk("t5_data", bus.ld_data, 32'hA0);
    bus.ld_req = 1'b0;

    // 6. reset mid-fill
    bus.ld_req  = 1'b1;
    bus.ld_addr = 32'h1A0;
    tick();
    chk("t6_in_fill", bus.mem_req, 1);
    bus.ld_req = 1'b0;
    reset      = 1'b1;
    tick();
    chk("t6_req_after_rst",  bus.mem_req, 0);
    chk("t6_busy_after_rst", bus.dc_busy, 0);
    reset = 1'b0;
    bus.ld_req  = 1'b1;
    bus.ld_addr = 32'h100;
    #1;
    chk("t6_relook_miss", bus.ld_hit, 0);
    tick();
    chk("t6_refill_we",   bus.mem_we,   0);
    chk("t6_refill_addr", bus.mem_addr, 32'h100);
    chk("t6_refill_busy", bus.dc_busy,  1);
    bus.ld_req = 1'b0;
    reset      = 1'b1;
    tick();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
